// File: rtl/alloc_pkg.sv
// Shared types and helpers for the dual resource allocator.
package alloc_pkg;

  // Requester lifecycle: waiting for nothing, waiting for grants, holding grants.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HELD = 2'd2
  } req_state_e;

  // Resource occupancy as seen by the arbiter.
  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } res_state_e;

  // Legal range for the number of requesters.
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  // Width that holds both the wait and the hold limits without wrapping.
  function automatic int cnt_width(input int wait_max, input int hold_max);
    int m;
    m = (wait_max > hold_max) ? wait_max : hold_max;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr (wrapping), one-hot, or zero when nothing is requested.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // Scan from ptr upward first, then wrap to the indices below ptr.
  always_comb begin
    gnt   = {N{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end else begin
        found = found;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/dual_resource_allocator.sv
// Shares resources A and B among N_REQ requesters with all-or-nothing
// grants. Optional watchdog (starvation reservation, hold timeout) is built
// when ALLOC_WATCHDOG_EN is defined; otherwise STARVE/TOUT are tied low.
module dual_resource_allocator
  import alloc_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WAIT_MAX = 17,
  parameter int HOLD_MAX = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQA,
  input  logic [N_REQ-1:0] REQB,
  output logic [N_REQ-1:0] GNTA,
  output logic [N_REQ-1:0] GNTB,
  output logic [N_REQ-1:0] STARVE,
  output logic [N_REQ-1:0] TOUT,
  output logic             ERR
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX || WAIT_MAX < 1 || HOLD_MAX < 1) begin : g_param_check
    $error("dual_resource_allocator: parameter out of range");
  end

  req_state_e       state_r     [N_REQ];
  req_state_e       state_nxt_s [N_REQ];
  logic [N_REQ-1:0] gnta_r, gntb_r, gnta_nxt_s, gntb_nxt_s;
  logic [N_REQ-1:0] cand1_s, cand2_s, win1_s, win2_s, win_s;
  logic [N_REQ-1:0] res_own_s;
  logic [PW-1:0]    ptr_r, ptr_nxt_s;
  logic             err_r, err_s;
  logic             take_a1_s, take_b1_s, res_a_s, res_b_s;
  res_state_e       res_a_st_s, res_b_st_s;

  // Pointer value just after the highest-order (last in rr order) winner.
  function automatic logic [PW-1:0] ptr_after(input logic [N_REQ-1:0] onehot);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) p = (i == N_REQ - 1) ? {PW{1'b0}} : PW'(i + 1);
      else           p = p;
    end
    return p;
  endfunction

  // Resource occupancy follows the grant registers; reservation follows the owner's live need.
  always_comb begin
    res_a_st_s = (|gnta_r) ? BUSY : FREE;
    res_b_st_s = (|gntb_r) ? BUSY : FREE;
    res_a_s    = |(res_own_s & REQA);
    res_b_s    = |(res_own_s & REQB);
  end

  // First pass: requesters whose whole need set is free and not reserved for someone else.
  always_comb begin
    cand1_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand1_s[i] = (state_r[i] != HELD) && (REQA[i] || REQB[i])
                && (!REQA[i] || ((res_a_st_s == FREE) && !(res_a_s && !res_own_s[i])))
                && (!REQB[i] || ((res_b_st_s == FREE) && !(res_b_s && !res_own_s[i])));
    end
  end

  rr_pick #(.N(N_REQ)) u_pass1 (.req(cand1_s), .ptr(ptr_r), .gnt(win1_s));

  // Second pass: remaining candidates whose needs are disjoint from the first winner.
  always_comb begin
    take_a1_s = |(win1_s & REQA);
    take_b1_s = |(win1_s & REQB);
    cand2_s   = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand2_s[i] = cand1_s[i] && !win1_s[i]
                && !(REQA[i] && take_a1_s) && !(REQB[i] && take_b1_s);
    end
  end

  rr_pick #(.N(N_REQ)) u_pass2 (.req(cand2_s), .ptr(ptr_r), .gnt(win2_s));

  assign win_s = win1_s | win2_s;

  // Requester transitions, grant/release, protocol check and pointer advance.
  always_comb begin
    err_s      = 1'b0;
    gnta_nxt_s = gnta_r;
    gntb_nxt_s = gntb_r;
    for (int i = 0; i < N_REQ; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        IDLE, PEND: begin
          if (win_s[i]) begin
            state_nxt_s[i] = HELD;
            gnta_nxt_s[i]  = REQA[i];
            gntb_nxt_s[i]  = REQB[i];
          end else if (REQA[i] || REQB[i]) begin
            state_nxt_s[i] = PEND;
            gnta_nxt_s[i]  = 1'b0;
            gntb_nxt_s[i]  = 1'b0;
          end else begin
            state_nxt_s[i] = IDLE;
            gnta_nxt_s[i]  = 1'b0;
            gntb_nxt_s[i]  = 1'b0;
          end
        end
        HELD: begin
          // Only held resources can be kept; new requests are flagged and ignored.
          gnta_nxt_s[i] = gnta_r[i] & REQA[i];
          gntb_nxt_s[i] = gntb_r[i] & REQB[i];
          if ((REQA[i] && !gnta_r[i]) || (REQB[i] && !gntb_r[i])) err_s = 1'b1;
          else                                                   err_s = err_s;
          if (!gnta_nxt_s[i] && !gntb_nxt_s[i]) state_nxt_s[i] = IDLE;
          else                                  state_nxt_s[i] = HELD;
        end
        default: begin
          state_nxt_s[i] = IDLE;
          gnta_nxt_s[i]  = 1'b0;
          gntb_nxt_s[i]  = 1'b0;
        end
      endcase
    end
    if (|win2_s)      ptr_nxt_s = ptr_after(win2_s);
    else if (|win1_s) ptr_nxt_s = ptr_after(win1_s);
    else              ptr_nxt_s = ptr_r;
  end

  // Requester state, grant, pointer and sticky error registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_REQ; i++) state_r[i] <= IDLE;
      gnta_r <= {N_REQ{1'b0}};
      gntb_r <= {N_REQ{1'b0}};
      ptr_r  <= {PW{1'b0}};
      err_r  <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) state_r[i] <= state_nxt_s[i];
      gnta_r <= gnta_nxt_s;
      gntb_r <= gntb_nxt_s;
      ptr_r  <= ptr_nxt_s;
      err_r  <= err_r | err_s;
    end
  end

  assign GNTA = gnta_r;
  assign GNTB = gntb_r;
  assign ERR  = err_r;

`ifdef ALLOC_WATCHDOG_EN
  localparam int            CW     = cnt_width(WAIT_MAX, HOLD_MAX);
  localparam logic [CW-1:0] WAIT_C = CW'(WAIT_MAX);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

  logic [CW-1:0]    wait_cnt_r [N_REQ];
  logic [CW-1:0]    wait_nxt_s [N_REQ];
  logic [CW-1:0]    hold_cnt_r [N_REQ];
  logic [CW-1:0]    hold_nxt_s [N_REQ];
  logic [N_REQ-1:0] pend_nxt_s, starve_nxt_s, tout_nxt_s, starve_win_s;
  logic [N_REQ-1:0] starve_r, tout_r, res_own_r;

  // Saturating wait/hold counters and the flags they drive.
  always_comb begin
    pend_nxt_s   = {N_REQ{1'b0}};
    starve_nxt_s = {N_REQ{1'b0}};
    tout_nxt_s   = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      pend_nxt_s[i] = (state_nxt_s[i] == PEND);
      if ((state_r[i] == PEND) && pend_nxt_s[i])
        wait_nxt_s[i] = (wait_cnt_r[i] == WAIT_C) ? WAIT_C : wait_cnt_r[i] + CW'(1);
      else
        wait_nxt_s[i] = {CW{1'b0}};
      if ((state_r[i] == HELD) && (state_nxt_s[i] == HELD))
        hold_nxt_s[i] = (hold_cnt_r[i] == HOLD_C) ? HOLD_C : hold_cnt_r[i] + CW'(1);
      else
        hold_nxt_s[i] = {CW{1'b0}};
      starve_nxt_s[i] = (wait_nxt_s[i] == WAIT_C);
      tout_nxt_s[i]   = (hold_nxt_s[i] == HOLD_C) && (hold_cnt_r[i] != HOLD_C);
    end
  end

  rr_pick #(.N(N_REQ)) u_starve (.req(starve_r), .ptr(ptr_r), .gnt(starve_win_s));

  // Counter, flag and single-reservation registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt_r[i] <= {CW{1'b0}};
        hold_cnt_r[i] <= {CW{1'b0}};
      end
      starve_r  <= {N_REQ{1'b0}};
      tout_r    <= {N_REQ{1'b0}};
      res_own_r <= {N_REQ{1'b0}};
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt_r[i] <= wait_nxt_s[i];
        hold_cnt_r[i] <= hold_nxt_s[i];
      end
      starve_r <= starve_nxt_s;
      tout_r   <= tout_nxt_s;
      // A reservation lives until its owner leaves PEND; only then may a new one form.
      if (res_own_r == {N_REQ{1'b0}})
        res_own_r <= starve_win_s & pend_nxt_s;
      else if (!(|(res_own_r & pend_nxt_s)))
        res_own_r <= {N_REQ{1'b0}};
      else
        res_own_r <= res_own_r;
    end
  end

  assign res_own_s = res_own_r;
  assign STARVE    = starve_r;
  assign TOUT      = tout_r;
`else
  assign res_own_s = {N_REQ{1'b0}};
  assign STARVE    = {N_REQ{1'b0}};
  assign TOUT      = {N_REQ{1'b0}};
`endif

endmodule

// File: tb/tb_dual_resource_allocator.sv
// Directed bench for dual_resource_allocator (N_REQ=4, WAIT_MAX=17, HOLD_MAX=64).
module tb_dual_resource_allocator;

`ifdef ALLOC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] REQA, REQB, GNTA, GNTB, STARVE, TOUT;
  logic       ERR;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ga;
    logic [3:0] gb;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  dual_resource_allocator #(.N_REQ(4), .WAIT_MAX(17), .HOLD_MAX(64)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQA(REQA), .REQB(REQB),
    .GNTA(GNTA), .GNTB(GNTB), .STARVE(STARVE), .TOUT(TOUT), .ERR(ERR)
  );

  task automatic check(input string what, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", what, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ga, input logic [3:0] gb,
                           input logic [3:0] st, input logic [3:0] to, input logic er);
    check({tag, " GNTA"}, GNTA, ga);
    check({tag, " GNTB"}, GNTB, gb);
    check({tag, " STARVE"}, STARVE, st);
    check({tag, " TOUT"}, TOUT, to);
    check({tag, " ERR"}, {3'b000, ERR}, {3'b000, er});
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQA  = 4'b0000;
    REQB  = 4'b0000;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    // reqa, reqb -> gnta, gntb, err after one edge
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}); // v0 idle
    vecs.push_back('{4'b0011, 4'b0011, 4'b0001, 4'b0001, 1'b0}); // v1 r0 wins both
    vecs.push_back('{4'b0011, 4'b0011, 4'b0001, 4'b0001, 1'b0}); // v2 r1 waits
    vecs.push_back('{4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0}); // v3 r0 drops
    vecs.push_back('{4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b0}); // v4 r1 gets both
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}); // v5
    vecs.push_back('{4'b0001, 4'b0010, 4'b0001, 4'b0010, 1'b0}); // v6 disjoint pair
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}); // v7
    vecs.push_back('{4'b1100, 4'b0000, 4'b0100, 4'b0000, 1'b0}); // v8 ptr=2 favours r2
    vecs.push_back('{4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0}); // v9 no same-edge handover
    vecs.push_back('{4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b0}); // v10 r3 gets A
    vecs.push_back('{4'b1000, 4'b0001, 4'b1000, 4'b0001, 1'b0}); // v11 r0 gets B
    vecs.push_back('{4'b0010, 4'b0001, 4'b0000, 4'b0001, 1'b0}); // v12 release + new request
    vecs.push_back('{4'b0010, 4'b0001, 4'b0010, 4'b0001, 1'b0}); // v13 grant one edge later
    vecs.push_back('{4'b0010, 4'b0011, 4'b0010, 4'b0001, 1'b1}); // v14 r1 raises B while held
    vecs.push_back('{4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1}); // v15 r0 frees B
    vecs.push_back('{4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1}); // v16 B free, still ignored
    vecs.push_back('{4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b1}); // v17 r1 drops A
    vecs.push_back('{4'b0000, 4'b0010, 4'b0000, 4'b0010, 1'b1}); // v18 r1 now IDLE, gets B
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1}); // v19 ERR sticky

    // Reset state, asynchronously and across an edge.
    RST_N = 1'b0;
    REQA  = 4'b0000;
    REQB  = 4'b0000;
    #1;
    check_all("reset async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    check_all("reset edge", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Table-driven single-edge behaviour.
    for (int v = 0; v < vecs.size(); v++) begin
      REQA = vecs[v].a;
      REQB = vecs[v].b;
      tick();
      check_all($sformatf("v%0d", v), vecs[v].ga, vecs[v].gb, 4'b0000, 4'b0000, vecs[v].err);
    end

    // Asynchronous reset while two requesters hold grants.
    REQA = 4'b0001;
    REQB = 4'b0010;
    tick();
    check_all("pre-reset", 4'b0001, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    #1;
    RST_N = 1'b0;
    #1;
    check_all("mid-hold reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check_all("post-reset grant", 4'b0001, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    REQA = 4'b0000;
    REQB = 4'b0000;
    tick();
    check_all("post-reset drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Starvation: r2 needs A+B while r0 then r1 hold A; r3 asks for B once r2 is reserved.
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      logic [3:0] ea, eb, es;
      if (k <= 9)       REQA = 4'b0111;
      else if (k == 10) REQA = 4'b0110;
      else if (k <= 20) REQA = 4'b0111;
      else              REQA = 4'b0101;
      REQB = (k >= 19) ? 4'b1100 : 4'b0100;
      tick();
      if (k <= 9)       ea = 4'b0001;
      else if (k == 10) ea = 4'b0000;
      else if (k <= 20) ea = 4'b0010;
      else if (k == 21) ea = 4'b0000;
      else              ea = WD ? 4'b0100 : 4'b0001;
      if (k < 19)       eb = 4'b0000;
      else if (k <= 21) eb = WD ? 4'b0000 : 4'b1000;
      else              eb = WD ? 4'b0100 : 4'b1000;
      es = (WD && k >= 17 && k <= 21) ? 4'b0100 : 4'b0000;
      check_all($sformatf("starve k%0d", k), ea, eb, es, 4'b0000, 1'b0);
    end
    REQA = 4'b0000;
    REQB = 4'b0000;
    tick();
    check_all("starve drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Hold timeout: r0 keeps A for 70 cycles; TOUT pulses once at hold count 64.
    do_reset();
    REQA = 4'b0001;
    tick();
    check("hold grant GNTA", GNTA, 4'b0001);
    for (int n = 1; n <= 70; n++) begin
      tick();
      check($sformatf("hold n%0d TOUT", n), TOUT, (WD && n == 64) ? 4'b0001 : 4'b0000);
      check($sformatf("hold n%0d GNTA", n), GNTA, 4'b0001);
    end
    REQA = 4'b0000;
    tick();
    check_all("hold drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
